multi_mode_timer: RTL
=====================

Name: multi_mode_timer

Overview:
- Parametrised successor to the single-width up/down saturating counter: programmable-width timer with a programmable step, up/down direction, three end-of-count policies and an explicit run/stop state machine.
- Sits beside the existing counter in the peripheral timer cluster.
- Drives a single-cycle timer_event pulse to the interrupt logic, plus running/done status.

Parameters:
- WIDTH, 32, width of count, din, sat_count and the internal reload register.
- STEP_W, 3, width of the step field; effective step = step + 1 (1..2^STEP_W).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- load  input  1  sync load: count <= din, reload_reg <= din.
- din  input  WIDTH  load / down-count reload value.
- sat_count  input  WIDTH  up-count terminal value, sampled live each tick.
- step  input  STEP_W  step field; effective step = step + 1.
- up_down  input  1  1 = count up, 0 = count down.
- enable  input  1  tick qualifier; low pauses counting in RUN.
- eoc_mode  input  2  end-of-count policy: 0 HOLD, 1 RELOAD, 2 ONESHOT, 3 reserved (behaves as HOLD).
- start  input  1  IDLE/DONE -> RUN.
- stop  input  1  RUN -> IDLE.
- count  output  WIDTH  current count, unsigned, registered.
- timer_event  output  1  one-cycle pulse on reaching the terminal value, registered.
- running  output  1  state == RUN.
- done  output  1  state == DONE.

Behaviour:
- Reset (rst low, asynchronous): count = 0, reload_reg = 0, state = IDLE, timer_event = 0, running = 0, done = 0. Takes effect without a clock edge and overrides all operation, including mid-run.
- States: IDLE, RUN, DONE. running and done are decoded from the state register.
- Per-edge priority: load > stop > start > tick.
  - load in any state: count <= din, reload_reg <= din, DONE -> IDLE, RUN stays RUN.
  - stop: RUN -> IDLE, count held.
  - start: IDLE/DONE -> RUN. start in RUN is ignored.
- A tick is a cycle with state == RUN and enable = 1. No tick means count holds and timer_event = 0.
- Arithmetic is unsigned. The up sum is computed in WIDTH+1 bits, so it never wraps silently. S denotes the effective step.
- Up tick (up_down = 1):
  - count >= sat_count (already at or past end): RELOAD -> count <= 0; HOLD -> hold; ONESHOT -> count <= sat_count, timer_event, -> DONE.
  - else if count + S >= sat_count: count <= sat_count, timer_event = 1, ONESHOT -> DONE.
  - else count <= count + S.
- Down tick (up_down = 0):
  - count == 0: RELOAD -> count <= reload_reg; HOLD -> hold; ONESHOT -> timer_event, -> DONE.
  - else if count <= S: count <= 0, timer_event = 1, ONESHOT -> DONE.
  - else count <= count - S.
- Overshoot never occurs; count is clamped to the terminal value (sat_count or 0).
- timer_event is asserted for exactly one cycle. It rises on the same edge at which count first shows the terminal value.
- HOLD parked at the terminal value produces no further events. Flipping up_down resumes normal counting.
- sat_count lowered below count while counting up: the next tick follows the "already at/past end" row.
- Direction, step and eoc_mode may change on any cycle and apply to the next tick.
- Latency: input to count/event change is one edge. Status follows the state register with zero extra latency.

Optional Feature:
- Macro: PRESCALE_EN.
- Defined:
  - Adds parameter PRESCALE_W (default 8) and input presc [PRESCALE_W-1:0].
  - An internal prescale counter increments on enabled RUN cycles and generates a tick when it equals presc, then clears. Count therefore advances once per presc+1 enabled cycles.
  - The prescale counter clears on reset, load, stop and start, and holds while enable = 0.
- Undefined: port and parameter are absent; every enabled RUN cycle is a tick.

Test Plan:
- Reset mid-run: RUN at count 17, pull rst low between edges -> count = 0, running = 0 immediately. After release, stays IDLE until start.
- Up HOLD: sat_count = 10, step = 2 (S = 3), start -> count 3, 6, 9, 10. timer_event high only on the cycle count = 10. count stays 10, running = 1.
- Up RELOAD: sat_count = 5, step = 0 -> 1, 2, 3, 4, 5 (event), 0, 1, ... Event period is 6 ticks. Toggle enable low for 3 cycles -> count frozen, period stretches by 3.
- Down ONESHOT: load din = 7, step = 2, start -> 4, 1, 0 (event). Then done = 1, running = 0, count held at 0. A further start -> next tick raises event and returns to DONE. A load of 7 -> IDLE, done = 0.
- Priority: load = 1, stop = 1 and start = 1 in the same cycle during RUN, din = 42 -> count = 42, state stays RUN. Next cycle stop alone -> IDLE, count = 42 held.
- PRESCALE_EN, presc = 3, up, step = 0, sat_count = 100 -> count increments every 4th enabled cycle. Issuing load resets the prescale phase.

Source files
------------

// File: rtl/multi_mode_timer.sv
// Programmable-width up/down timer with selectable step, HOLD/RELOAD/ONESHOT end-of-count policy and IDLE/RUN/DONE control.
// Optional tick prescaler enabled by defining PRESCALE_EN.
module multi_mode_timer #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STEP_W = 3
`ifdef PRESCALE_EN
    ,
    parameter int unsigned PRESCALE_W = 8
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WIDTH-1:0]  din,
    input  logic [WIDTH-1:0]  sat_count,
    input  logic [STEP_W-1:0] step,
    input  logic              up_down,
    input  logic              enable,
    input  logic [1:0]        eoc_mode,
    input  logic              start,
    input  logic              stop,
`ifdef PRESCALE_EN
    input  logic [PRESCALE_W-1:0] presc,
`endif
    output logic [WIDTH-1:0]  count,
    output logic              timer_event,
    output logic              running,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef enum logic [1:0] {
        EOC_HOLD    = 2'd0,
        EOC_RELOAD  = 2'd1,
        EOC_ONESHOT = 2'd2,
        EOC_RSVD    = 2'd3
    } eoc_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             event_q, event_d;
    logic             tick;
    eoc_e             mode;

    logic [WIDTH:0] step_eff;
    logic [WIDTH:0] up_sum;
    logic [WIDTH:0] count_ext;
    logic [WIDTH:0] sat_ext;

    assign mode      = eoc_e'(eoc_mode);
    assign step_eff  = {{(WIDTH + 1 - STEP_W){1'b0}}, step} + {{WIDTH{1'b0}}, 1'b1};
    assign count_ext = {1'b0, count_q};
    assign sat_ext   = {1'b0, sat_count};
    assign up_sum    = count_ext + step_eff;

`ifdef PRESCALE_EN
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  presc_hit;

    assign presc_hit = (presc_q == presc);

    always_comb begin
        presc_d = presc_q;
        if (load || stop || (start && state_q != RUN)) begin
            presc_d = '0;
        end else if (state_q == RUN && enable) begin
            presc_d = presc_hit ? '0 : presc_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) presc_q <= '0;
        else      presc_q <= presc_d;
    end

    assign tick = (state_q == RUN) && enable && !load && !stop && presc_hit;
`else
    assign tick = (state_q == RUN) && enable && !load && !stop;
`endif

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        state_d  = state_q;
        event_d  = 1'b0;
        if (load) begin
            count_d  = din;
            reload_d = din;
            if (state_q == DONE) state_d = IDLE;
        end else if (stop) begin
            if (state_q == RUN) state_d = IDLE;
        end else if (start && state_q != RUN) begin
            state_d = RUN;
        end else if (tick) begin
            if (up_down) begin
                // Past-the-end case covers sat_count being lowered below count mid-run.
                if (count_ext >= sat_ext) begin
                    if (mode == EOC_RELOAD) begin
                        count_d = '0;
                    end else if (mode == EOC_ONESHOT) begin
                        count_d = sat_count;
                        event_d = 1'b1;
                        state_d = DONE;
                    end
                end else if (up_sum >= sat_ext) begin
                    count_d = sat_count;
                    event_d = 1'b1;
                    if (mode == EOC_ONESHOT) state_d = DONE;
                end else begin
                    count_d = up_sum[WIDTH-1:0];
                end
            end else begin
                if (count_q == '0) begin
                    if (mode == EOC_RELOAD) begin
                        count_d = reload_q;
                    end else if (mode == EOC_ONESHOT) begin
                        event_d = 1'b1;
                        state_d = DONE;
                    end
                end else if (count_ext <= step_eff) begin
                    count_d = '0;
                    event_d = 1'b1;
                    if (mode == EOC_ONESHOT) state_d = DONE;
                end else begin
                    count_d = count_q - step_eff[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            event_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            event_q  <= event_d;
        end
    end

    assign count       = count_q;
    assign timer_event = event_q;
    assign running     = (state_q == RUN);
    assign done        = (state_q == DONE);

endmodule
